// File: rtl/wb_retire_stage_pkg.sv
// Shared definitions for the writeback/retire stage: class-bit indices, queue FSM
// encoding and the field layout of the MEM->WB bundle.
package wb_retire_stage_pkg;

  localparam int CLS_BR  = 0;
  localparam int CLS_MEM = 1;
  localparam int DEST_W  = 5;

  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } q_state_t;

  // MEM->WB bundle is {cls, dest, rf_wen, wdata, pc}, pc in the low bits.
  function automatic int mw_wdata_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int mw_wen_bit(input int xlen);
    return 2 * xlen;
  endfunction

  function automatic int mw_dest_lsb(input int xlen);
    return 2 * xlen + 1;
  endfunction

  function automatic int mw_cls_lsb(input int xlen);
    return 2 * xlen + 1 + DEST_W;
  endfunction

endpackage

// File: rtl/wb_retire_stage_retire_queue.sv
// Power-of-two circular retire queue with an EMPTY/PARTIAL/FULL state machine;
// full and empty are registered alongside the state.
module wb_retire_stage_retire_queue
  import wb_retire_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 72
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  q_state_t      state;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= Q_EMPTY;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // Simultaneous push and pop leaves occupancy, and therefore state, unchanged.
      case (state)
        Q_EMPTY: begin
          if (push && !pop) begin
            state <= Q_PARTIAL;
            empty <= 1'b0;
          end
        end
        Q_PARTIAL: begin
          if (push && !pop && count == CW'(DEPTH - 1)) begin
            state <= Q_FULL;
            full  <= 1'b1;
          end else if (pop && !push && count == CW'(1)) begin
            state <= Q_EMPTY;
            empty <= 1'b1;
          end
        end
        Q_FULL: begin
          if (pop && !push) begin
            state <= Q_PARTIAL;
            full  <= 1'b0;
          end
        end
        default: begin
          state <= Q_EMPTY;
          full  <= 1'b0;
          empty <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback stage: holds the MEM result for one cycle, writes the RF, feeds ID
// forwarding, and streams retire records through a queue with per-class counters.
module wb_retire_stage
  import wb_retire_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int NUM_CLS  = 2,
  parameter int CNT_W    = 32,
  parameter bit TRACE_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_to_wb_valid,
  input  logic [NUM_CLS+6+2*XLEN-1:0] mem_to_wb_data,
  output logic                       wb_allowin,
  output logic [6+XLEN-1:0]          wb_to_rf_data,
  output logic [2*XLEN+6-1:0]        wb_to_id_fw_data,
  input  logic                       inst_retired_fifo_full,
  output logic                       inst_retire_valid,
  output logic [2*XLEN+6-1:0]        inst_retired,
  input  logic                       cnt_clear,
  output logic [CNT_W-1:0]           valid_inst_cnt,
  output logic [NUM_CLS*CNT_W-1:0]   cls_inst_cnt
);

  localparam int IN_W  = NUM_CLS + 6 + 2 * XLEN;
  localparam int REC_W = 2 * XLEN + 6;
  localparam int ENT_W = REC_W + NUM_CLS;

  logic                            wb_vld_p0;
  logic [IN_W-1:0]                 wb_data_p0;
  logic                            wb_go;
  logic                            q_full;
  logic                            q_pop;
  logic                            cnt_inc;
  logic [NUM_CLS-1:0]              cnt_cls;
  logic [CNT_W-1:0]                valid_cnt;
  logic [NUM_CLS-1:0][CNT_W-1:0]   cls_cnt;

  logic [XLEN-1:0]    wb_pc;
  logic [XLEN-1:0]    wb_wdata;
  logic               wb_wen;
  logic [DEST_W-1:0]  wb_dest;
  logic [NUM_CLS-1:0] wb_cls;

  assign wb_pc    = wb_data_p0[XLEN-1:0];
  assign wb_wdata = wb_data_p0[mw_wdata_lsb(XLEN) +: XLEN];
  assign wb_wen   = wb_data_p0[mw_wen_bit(XLEN)];
  assign wb_dest  = wb_data_p0[mw_dest_lsb(XLEN) +: DEST_W];
  assign wb_cls   = wb_data_p0[mw_cls_lsb(XLEN) +: NUM_CLS];

  assign wb_go      = wb_vld_p0 & (!q_full | q_pop);
  assign wb_allowin = !wb_vld_p0 | wb_go;

  // p0: WB register, loaded from MEM whenever the stage can advance
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld_p0  <= 1'b0;
      wb_data_p0 <= '0;
    end else if (wb_allowin) begin
      wb_vld_p0 <= mem_to_wb_valid;
      if (mem_to_wb_valid) wb_data_p0 <= mem_to_wb_data;
    end
  end

  assign wb_to_rf_data    = {wb_go & wb_wen, wb_dest, wb_wdata};
  assign wb_to_id_fw_data = {wb_pc, wb_vld_p0 & wb_wen, wb_dest, wb_wdata};

  generate
    if (TRACE_EN) begin : g_trace
      logic [ENT_W-1:0] q_head;
      logic             q_empty;

      wb_retire_stage_retire_queue #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
      ) u_retire_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (wb_go),
        .pop   (q_pop),
        .din   ({wb_cls, wb_pc, wb_wen, wb_dest, wb_wdata}),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty)
      );

      assign inst_retire_valid = !q_empty;
      assign q_pop             = inst_retire_valid & !inst_retired_fifo_full;
      assign inst_retired      = q_head[REC_W-1:0];
      assign cnt_inc           = q_pop;
      assign cnt_cls           = q_head[ENT_W-1 -: NUM_CLS];
    end else begin : g_no_trace
      assign inst_retire_valid = 1'b0;
      assign q_pop             = 1'b0;
      assign q_full            = 1'b0;
      assign inst_retired      = '0;
      assign cnt_inc           = wb_go;
      assign cnt_cls           = wb_cls;
    end
  endgenerate

  // p1: perf counters, clear wins over a same-cycle retire
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      valid_cnt <= '0;
      cls_cnt   <= '0;
    end else if (cnt_inc) begin
      valid_cnt <= valid_cnt + CNT_W'(1);
      for (int i = 0; i < NUM_CLS; i++) begin
        if (cnt_cls[i]) cls_cnt[i] <= cls_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign valid_inst_cnt = valid_cnt;
  assign cls_inst_cnt   = cls_cnt;

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed bench for wb_retire_stage: ordering, back-pressure, pop-through,
// duplicate records, counter clear/wrap and mid-run reset.
module tb_wb_retire_stage;
  import wb_retire_stage_pkg::*;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int NUM_CLS = 2;
  localparam int CNT_W   = 8;
  localparam int IN_W    = NUM_CLS + 6 + 2 * XLEN;
  localparam logic [1:0] BR  = 2'(1 << CLS_BR);
  localparam logic [1:0] MEM = 2'(1 << CLS_MEM);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     mem_to_wb_valid;
  logic [IN_W-1:0]          mem_to_wb_data;
  logic                     wb_allowin;
  logic [6+XLEN-1:0]        wb_to_rf_data;
  logic [2*XLEN+6-1:0]      wb_to_id_fw_data;
  logic                     inst_retired_fifo_full;
  logic                     inst_retire_valid;
  logic [2*XLEN+6-1:0]      inst_retired;
  logic                     cnt_clear;
  logic [CNT_W-1:0]         valid_inst_cnt;
  logic [NUM_CLS*CNT_W-1:0] cls_inst_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  int rf_wr_cnt;
  int stall_cnt;
  logic [XLEN-1:0] ret_q[$];

  wb_retire_stage #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .NUM_CLS  (NUM_CLS),
    .CNT_W    (CNT_W),
    .TRACE_EN (1'b1)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem_to_wb_valid        (mem_to_wb_valid),
    .mem_to_wb_data         (mem_to_wb_data),
    .wb_allowin             (wb_allowin),
    .wb_to_rf_data          (wb_to_rf_data),
    .wb_to_id_fw_data       (wb_to_id_fw_data),
    .inst_retired_fifo_full (inst_retired_fifo_full),
    .inst_retire_valid      (inst_retire_valid),
    .inst_retired           (inst_retired),
    .cnt_clear              (cnt_clear),
    .valid_inst_cnt         (valid_inst_cnt),
    .cls_inst_cnt           (cls_inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] mk(input logic [1:0] cls, input logic [4:0] dest,
                                         input logic wen, input logic [XLEN-1:0] wdata,
                                         input logic [XLEN-1:0] pc);
    return {cls, dest, wen, wdata, pc};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] d);
    bit ok = 1'b0;
    mem_to_wb_valid = 1'b1;
    mem_to_wb_data  = d;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = wb_allowin;
      @(posedge clk);
      #1;
    end
    mem_to_wb_valid = 1'b0;
    if (!ok) check_vec("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_pcs(input string tag, input logic [XLEN-1:0] base, input int n);
    check_vec({tag, "_count"}, 64'(ret_q.size()), 64'(n));
    for (int i = 0; i < n && i < ret_q.size(); i++)
      check_vec({tag, "_pc"}, 64'(ret_q[i]), 64'(base + XLEN'(4 * i)));
  endtask

  // Handshakes observed mid-cycle, after inputs have settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_retire_valid && !inst_retired_fifo_full)
        ret_q.push_back(inst_retired[2*XLEN+5 -: XLEN]);
      if (wb_to_rf_data[XLEN+5]) rf_wr_cnt++;
      if (mem_to_wb_valid && !wb_allowin) stall_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_to_wb_valid = 1'b0;
    mem_to_wb_data = '0;
    inst_retired_fifo_full = 1'b0;
    cnt_clear = 1'b0;
    step(3);
    rst = 1'b0;
    check_vec("rst_retire_valid", 64'(inst_retire_valid), 64'd0);
    check_vec("rst_allowin", 64'(wb_allowin), 64'd1);
    check_vec("rst_valid_cnt", 64'(valid_inst_cnt), 64'd0);
    check_vec("rst_cls_cnt", 64'(cls_inst_cnt), 64'd0);
    check_vec("rst_rf_we", 64'(wb_to_rf_data[XLEN+5]), 64'd0);
    check_vec("rst_fw_en", 64'(wb_to_id_fw_data[XLEN+5]), 64'd0);

    // Three back-to-back instructions, no back-pressure.
    ret_q.delete(); rf_wr_cnt = 0; stall_cnt = 0;
    send(mk(BR,  5'd1, 1'b1, 32'hA1, 32'h0));
    send(mk(MEM, 5'd2, 1'b1, 32'hA2, 32'h4));
    send(mk(2'b00, 5'd3, 1'b1, 32'hA3, 32'h8));
    step(4);
    check_pcs("b2b", 32'h0, 3);
    check_vec("b2b_rf_writes", 64'(rf_wr_cnt), 64'd3);
    check_vec("b2b_stalls", 64'(stall_cnt), 64'd0);
    check_vec("b2b_valid_cnt", 64'(valid_inst_cnt), 64'd3);
    check_vec("b2b_cls_br", 64'(cls_inst_cnt[0 +: CNT_W]), 64'd1);
    check_vec("b2b_cls_mem", 64'(cls_inst_cnt[CNT_W +: CNT_W]), 64'd1);

    // Back-pressure: 4 queued, 5th held in WB, then drain.
    ret_q.delete();
    inst_retired_fifo_full = 1'b1;
    fork
      for (int i = 0; i < 8; i++)
        send(mk(2'b00, 5'(i + 4), 1'b1, 32'hB0 + 32'(i), 32'h100 + 32'(4 * i)));
      begin
        step(10);
        check_vec("bp_allowin", 64'(wb_allowin), 64'd0);
        check_vec("bp_retire_valid", 64'(inst_retire_valid), 64'd1);
        check_vec("bp_head_pc", 64'(inst_retired[2*XLEN+5 -: XLEN]), 64'h100);
        check_vec("bp_head_wdata", 64'(inst_retired[XLEN-1:0]), 64'hB0);
        check_vec("bp_fw_pc", 64'(wb_to_id_fw_data[2*XLEN+5 -: XLEN]), 64'h110);
        check_vec("bp_fw_en", 64'(wb_to_id_fw_data[XLEN+5]), 64'd1);
        check_vec("bp_rf_we", 64'(wb_to_rf_data[XLEN+5]), 64'd0);
        check_vec("bp_none_retired", 64'(ret_q.size()), 64'd0);
        inst_retired_fifo_full = 1'b0;
      end
    join
    step(12);
    check_pcs("bp", 32'h100, 8);
    check_vec("bp_valid_cnt", 64'(valid_inst_cnt), 64'd11);

    // Pop-through: queue full with WB valid, FIFO frees up.
    ret_q.delete();
    inst_retired_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++)
      send(mk(2'b00, 5'd9, 1'b1, 32'hC0, 32'h200 + 32'(4 * i)));
    step(2);
    check_vec("pt_full_allowin", 64'(wb_allowin), 64'd0);
    inst_retired_fifo_full = 1'b0;
    @(negedge clk);
    check_vec("pt_allowin", 64'(wb_allowin), 64'd1);
    check_vec("pt_rf_we", 64'(wb_to_rf_data[XLEN+5]), 64'd1);
    step(10);
    check_pcs("pt", 32'h200, 5);
    check_vec("pt_valid_cnt", 64'(valid_inst_cnt), 64'd16);

    // Identical records back-to-back both retire.
    ret_q.delete();
    send(mk(2'b00, 5'd7, 1'b1, 32'hDD, 32'h300));
    send(mk(2'b00, 5'd7, 1'b1, 32'hDD, 32'h300));
    step(5);
    check_vec("dup_count", 64'(ret_q.size()), 64'd2);
    for (int i = 0; i < 2 && i < ret_q.size(); i++)
      check_vec("dup_pc", 64'(ret_q[i]), 64'h300);
    check_vec("dup_valid_cnt", 64'(valid_inst_cnt), 64'd18);

    // Reset with three records queued drops them.
    ret_q.delete();
    inst_retired_fifo_full = 1'b1;
    for (int i = 0; i < 3; i++)
      send(mk(BR, 5'd1, 1'b1, 32'hE0, 32'h400 + 32'(4 * i)));
    step(2);
    check_vec("mrst_pre_valid", 64'(inst_retire_valid), 64'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_vec("mrst_retire_valid", 64'(inst_retire_valid), 64'd0);
    check_vec("mrst_valid_cnt", 64'(valid_inst_cnt), 64'd0);
    check_vec("mrst_cls_cnt", 64'(cls_inst_cnt), 64'd0);
    check_vec("mrst_allowin", 64'(wb_allowin), 64'd1);
    inst_retired_fifo_full = 1'b0;
    step(5);
    check_vec("mrst_dropped", 64'(ret_q.size()), 64'd0);

    // Clear on the same cycle as a cls=11 retire.
    send(mk(BR, 5'd1, 1'b1, 32'h1, 32'h500));
    step(4);
    check_vec("clr_pre_cnt", 64'(valid_inst_cnt), 64'd1);
    inst_retired_fifo_full = 1'b1;
    send(mk(2'b11, 5'd1, 1'b1, 32'h2, 32'h504));
    step(2);
    inst_retired_fifo_full = 1'b0;
    cnt_clear = 1'b1;
    step(1);
    cnt_clear = 1'b0;
    check_vec("clr_valid_cnt", 64'(valid_inst_cnt), 64'd0);
    check_vec("clr_cls_cnt", 64'(cls_inst_cnt), 64'd0);
    check_vec("clr_retired", 64'(ret_q.size()), 64'd2);
    send(mk(2'b11, 5'd1, 1'b1, 32'h3, 32'h508));
    step(4);
    check_vec("cls11_valid_cnt", 64'(valid_inst_cnt), 64'd1);
    check_vec("cls11_br_cnt", 64'(cls_inst_cnt[0 +: CNT_W]), 64'd1);
    check_vec("cls11_mem_cnt", 64'(cls_inst_cnt[CNT_W +: CNT_W]), 64'd1);

    // Counter wrap at 2^CNT_W.
    for (int i = 0; i < 254; i++)
      send(mk(BR, 5'd2, 1'b0, 32'h0, 32'h1000 + 32'(4 * i)));
    step(4);
    check_vec("wrap_max_valid", 64'(valid_inst_cnt), 64'hFF);
    check_vec("wrap_max_br", 64'(cls_inst_cnt[0 +: CNT_W]), 64'hFF);
    send(mk(BR, 5'd2, 1'b0, 32'h0, 32'h2000));
    step(4);
    check_vec("wrap_valid", 64'(valid_inst_cnt), 64'd0);
    check_vec("wrap_br", 64'(cls_inst_cnt[0 +: CNT_W]), 64'd0);
    check_vec("wrap_mem_held", 64'(cls_inst_cnt[CNT_W +: CNT_W]), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
